// File: rtl/gpio_irq_svc.sv
// gpio_irq_svc: AXI-Lite master that initialises a GPIO block and services its level interrupt.
// Define GPIO_IRQ_SVC_TIMEOUT_EN to build in the per-transaction handshake watchdog.
module gpio_irq_svc #(
    parameter int          AXI_ADDR_WIDTH = 12,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter logic [31:0] DIR_INIT       = 32'h0,
    parameter logic [31:0] EDGE_EN_INIT   = 32'h0,
    parameter logic [31:0] EDGE_POL_INIT  = 32'h0,
    parameter logic [31:0] MASK_INIT      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          init_start,
    output logic                          init_done,
    input  logic                          irq,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [31:0]                   evt_status,
    output logic                          err,
    output logic [AXI_ADDR_WIDTH-1:0]     m_awaddr,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_araddr,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT_WR = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RD_STAT = 3'd4;
    localparam logic [2:0] S_CLR     = 3'd5;
    localparam logic [2:0] S_EVT     = 3'd6;
    localparam logic [2:0] S_ABORT   = 3'd7;

    localparam int SW = AXI_DATA_WIDTH / 8;

    localparam logic [AXI_ADDR_WIDTH-1:0] A_DIR      = AXI_ADDR_WIDTH'(12'h000);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_MASK     = AXI_ADDR_WIDTH'(12'h014);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_STATUS   = AXI_ADDR_WIDTH'(12'h018);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_CLEAR    = AXI_ADDR_WIDTH'(12'h01C);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_EDGE_EN  = AXI_ADDR_WIDTH'(12'h020);
    localparam logic [AXI_ADDR_WIDTH-1:0] A_EDGE_POL = AXI_ADDR_WIDTH'(12'h024);

    function automatic logic [AXI_ADDR_WIDTH-1:0] init_addr(input logic [1:0] k);
        case (k)
            2'd0:    init_addr = A_DIR;
            2'd1:    init_addr = A_EDGE_EN;
            2'd2:    init_addr = A_EDGE_POL;
            2'd3:    init_addr = A_MASK;
            default: init_addr = A_DIR;
        endcase
    endfunction

    function automatic logic [AXI_DATA_WIDTH-1:0] init_data(input logic [1:0] k);
        case (k)
            2'd0:    init_data = AXI_DATA_WIDTH'(DIR_INIT);
            2'd1:    init_data = AXI_DATA_WIDTH'(EDGE_EN_INIT);
            2'd2:    init_data = AXI_DATA_WIDTH'(EDGE_POL_INIT);
            2'd3:    init_data = AXI_DATA_WIDTH'(MASK_INIT);
            default: init_data = AXI_DATA_WIDTH'(DIR_INIT);
        endcase
    endfunction

    logic [2:0]                r_state;
    logic [1:0]                r_k;
    logic                      r_hold;
    logic [31:0]               r_status;
    logic                      r_init_done;
    logic                      r_err;
    logic                      r_evt_valid;
    logic [31:0]               r_evt_status;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic                      r_awvalid;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [SW-1:0]             r_wstrb;
    logic                      r_wvalid;
    logic                      r_bready;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic                      r_arvalid;
    logic                      r_rready;

    logic w_wr_done;
    logic w_rd_done;
    logic w_timeout;

    assign w_wr_done = r_bready && m_bvalid;
    assign w_rd_done = r_rready && m_rvalid;

`ifdef GPIO_IRQ_SVC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          w_busy;
    logic [TW-1:0] r_to_cnt;

    assign w_busy    = (r_state == S_INIT_WR) || (r_state == S_RD_STAT) || (r_state == S_CLR);
    assign w_timeout = w_busy && !w_wr_done && !w_rd_done && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Cycles the current AXI transaction has been outstanding; restarts at every issue.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_to_cnt <= {TW{1'b0}};
        end else if (!w_busy || w_wr_done || w_rd_done) begin
            r_to_cnt <= {TW{1'b0}};
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Sequencer FSM and all AXI/event output registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_k          <= 2'd0;
            r_hold       <= 1'b0;
            r_status     <= 32'h0;
            r_init_done  <= 1'b0;
            r_err        <= 1'b0;
            r_evt_valid  <= 1'b0;
            r_evt_status <= 32'h0;
            r_awaddr     <= {AXI_ADDR_WIDTH{1'b0}};
            r_awvalid    <= 1'b0;
            r_wdata      <= {AXI_DATA_WIDTH{1'b0}};
            r_wstrb      <= {SW{1'b0}};
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_araddr     <= {AXI_ADDR_WIDTH{1'b0}};
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
        end else if (w_timeout) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_evt_valid <= 1'b0;
            r_err       <= 1'b1;
            r_init_done <= 1'b0;
            r_state     <= S_ABORT;
        end else begin
            // Channel bookkeeping shared by every transaction; the state case may re-issue after it.
            if (r_awvalid && m_awready) r_awvalid <= 1'b0;
            if (r_wvalid && m_wready)   r_wvalid  <= 1'b0;
            if (r_arvalid && m_arready) r_arvalid <= 1'b0;
            if (w_wr_done) begin
                r_bready <= 1'b0;
                if (m_bresp != 2'b00) r_err <= 1'b1;
            end
            if (w_rd_done) begin
                r_rready <= 1'b0;
                if (m_rresp != 2'b00) r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (init_start) begin
                        r_k       <= 2'd0;
                        r_awaddr  <= init_addr(2'd0);
                        r_wdata   <= init_data(2'd0);
                        r_wstrb   <= {SW{1'b1}};
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_bready  <= 1'b1;
                        r_state   <= S_INIT_WR;
                    end
                end
                S_INIT_WR: begin
                    if (w_wr_done) begin
                        if (r_k == 2'd3) begin
                            r_init_done <= 1'b1;
                            r_hold      <= 1'b0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_k       <= r_k + 2'd1;
                            r_awaddr  <= init_addr(r_k + 2'd1);
                            r_wdata   <= init_data(r_k + 2'd1);
                            r_wstrb   <= {SW{1'b1}};
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_bready  <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // Two-cycle blind window while the GPIO's cleared status propagates to irq.
                    if (r_hold) begin
                        r_hold  <= 1'b0;
                        r_state <= S_RUN;
                    end else begin
                        r_hold <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (irq) begin
                        r_araddr  <= A_STATUS;
                        r_arvalid <= 1'b1;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_STAT;
                    end
                end
                S_RD_STAT: begin
                    if (w_rd_done) begin
                        r_status <= 32'(m_rdata);
                        if (m_rdata == {AXI_DATA_WIDTH{1'b0}}) begin
                            r_hold  <= 1'b0;
                            r_state <= S_HOLD;
                        end else begin
                            r_awaddr  <= A_CLEAR;
                            r_wdata   <= m_rdata;
                            r_wstrb   <= {SW{1'b1}};
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_bready  <= 1'b1;
                            r_state   <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    if (w_wr_done) begin
                        r_evt_valid  <= 1'b1;
                        r_evt_status <= r_status;
                        r_state      <= S_EVT;
                    end
                end
                S_EVT: begin
                    if (evt_ready) begin
                        r_evt_valid <= 1'b0;
                        r_hold      <= 1'b0;
                        r_state     <= S_HOLD;
                    end
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign init_done  = r_init_done;
    assign err        = r_err;
    assign evt_valid  = r_evt_valid;
    assign evt_status = r_evt_status;
    assign m_awaddr   = r_awaddr;
    assign m_awvalid  = r_awvalid;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign m_wvalid   = r_wvalid;
    assign m_bready   = r_bready;
    assign m_araddr   = r_araddr;
    assign m_arvalid  = r_arvalid;
    assign m_rready   = r_rready;

endmodule

// File: tb/tb_gpio_irq_svc.sv
// Directed bench for gpio_irq_svc: a reactive AXI-Lite GPIO slave model plus per-feature test tasks.
// Compile with GPIO_IRQ_SVC_TIMEOUT_EN defined to also exercise the watchdog scenario.
module tb_gpio_irq_svc;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        init_start = 1'b0;
    logic        init_done;
    logic        irq = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [31:0] evt_status;
    logic        err;
    logic [11:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [11:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  m_rresp = 2'b00;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    gpio_irq_svc #(
        .AXI_ADDR_WIDTH (12),
        .AXI_DATA_WIDTH (32),
        .DIR_INIT       (32'h0),
        .EDGE_EN_INIT   (32'hFFFF_FFFF),
        .EDGE_POL_INIT  (32'h0),
        .MASK_INIT      (32'h1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk(aclk), .areset(areset), .init_start(init_start), .init_done(init_done),
        .irq(irq), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_status(evt_status), .err(err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int passed = 0;

    // Slave model state and observation counters.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit          aw_have = 1'b0, w_have = 1'b0, ar_have = 1'b0;
    logic [11:0] aw_addr_c = 12'h0, ar_addr_c = 12'h0;
    logic [31:0] w_data_c = 32'h0;
    logic [31:0] regs [16];
    logic [31:0] gpio_status = 32'h0;
    logic        irq_force = 1'b0;
    logic [11:0] err_addr = 12'hFFF;
    logic [11:0] wa_q [$];
    logic [31:0] wd_q [$];
    int          rd_cnt = 0, aw_hi = 0, w_hi = 0, ar_hi = 0, evt_hi = 0, bad_strb = 0;

    logic [11:0] exp_a [4] = '{12'h000, 12'h020, 12'h024, 12'h014};
    logic [31:0] exp_d [4] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1};

    // GPIO register-file slave: reacts on the falling edge, so handshakes land on the next rising edge.
    always @(negedge aclk) begin
        if (areset) begin
            m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
            m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = 2'b00;
            aw_have = 1'b0; w_have = 1'b0; ar_have = 1'b0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
        end else begin
            if (m_awvalid) aw_hi++;
            if (m_wvalid) w_hi++;
            if (m_arvalid) ar_hi++;
            if (evt_valid) evt_hi++;
            if (m_wvalid && m_wstrb !== 4'hF) bad_strb++;
            if (m_bvalid) begin
                m_bvalid = 1'b0;
            end else if (aw_have && w_have) begin
                m_bvalid = 1'b1;
                m_bresp  = (aw_addr_c == err_addr) ? 2'b10 : 2'b00;
                wa_q.push_back(aw_addr_c);
                wd_q.push_back(w_data_c);
                if (aw_addr_c == 12'h01C) gpio_status = gpio_status & ~w_data_c;
                else regs[aw_addr_c[5:2]] = w_data_c;
                aw_have = 1'b0; w_have = 1'b0;
            end
            if (m_awvalid && !aw_have) begin
                if (aw_wait >= aw_delay) begin
                    m_awready = 1'b1; aw_have = 1'b1; aw_addr_c = m_awaddr; aw_wait = 0;
                end else begin
                    m_awready = 1'b0; aw_wait++;
                end
            end else m_awready = 1'b0;
            if (m_wvalid && !w_have) begin
                if (w_wait >= w_delay) begin
                    m_wready = 1'b1; w_have = 1'b1; w_data_c = m_wdata; w_wait = 0;
                end else begin
                    m_wready = 1'b0; w_wait++;
                end
            end else m_wready = 1'b0;
            if (m_rvalid) begin
                m_rvalid = 1'b0;
            end else if (ar_have) begin
                m_rvalid = 1'b1;
                m_rresp  = 2'b00;
                m_rdata  = (ar_addr_c == 12'h018) ? gpio_status : regs[ar_addr_c[5:2]];
                rd_cnt++;
                ar_have = 1'b0;
            end
            if (m_arvalid && !ar_have) begin
                if (ar_wait >= ar_delay) begin
                    m_arready = 1'b1; ar_have = 1'b1; ar_addr_c = m_araddr; ar_wait = 0;
                end else begin
                    m_arready = 1'b0; ar_wait++;
                end
            end else m_arready = 1'b0;
        end
        irq = irq_force | (|(gpio_status & regs[5]));
    end

    task automatic do_init();
        int n;
        @(negedge aclk); init_start = 1'b1;
        @(negedge aclk); init_start = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
        checks++;
        if (init_done !== 1'b1) $display("FAIL init_wait: init_done=%b after %0d cycles, want 1", init_done, n);
        else passed++;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, init_done, err, evt_valid} !== 8'h00)
            $display("FAIL reset_ctrl: ctrl bits=%b, want 00000000",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, init_done, err, evt_valid});
        else passed++;
        checks++;
        if (evt_status !== 32'h0) $display("FAIL reset_evt_status: got %h want 0", evt_status); else passed++;
        checks++;
        if ({m_awaddr, m_araddr, m_wdata, m_wstrb} !== 60'h0)
            $display("FAIL reset_addr_data: aw=%h ar=%h wd=%h ws=%h, want 0", m_awaddr, m_araddr, m_wdata, m_wstrb);
        else passed++;
        areset = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if (m_awvalid !== 1'b0) $display("FAIL idle_no_start: awvalid=%b want 0", m_awvalid); else passed++;
    endtask

    task automatic test_init();
        wa_q.delete(); wd_q.delete(); bad_strb = 0;
        do_init();
        checks++;
        if (wa_q.size() != 4) $display("FAIL init_count: got %0d writes want 4", wa_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (i < wa_q.size()) begin
                checks++;
                if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i])
                    $display("FAIL init_wr%0d: addr=%h data=%h want addr=%h data=%h", i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
                else passed++;
            end
        end
        checks++;
        if (err !== 1'b0) $display("FAIL init_err: got %b want 0", err); else passed++;
        checks++;
        if (regs[5] !== 32'h1) $display("FAIL init_mask_readback: got %h want 1", regs[5]); else passed++;
        checks++;
        if (bad_strb != 0) $display("FAIL init_wstrb: %0d bad strobe cycles want 0", bad_strb); else passed++;
        repeat (4) @(negedge aclk);
    endtask

    task automatic test_ignore_init_start();
        wa_q.delete(); wd_q.delete();
        @(negedge aclk); init_start = 1'b1;
        @(negedge aclk); init_start = 1'b0;
        repeat (10) @(negedge aclk);
        checks++;
        if (wa_q.size() != 0 || init_done !== 1'b1)
            $display("FAIL ignore_init_start: writes=%0d init_done=%b want 0 and 1", wa_q.size(), init_done);
        else passed++;
    endtask

    task automatic test_irq_service();
        int n;
        bit stable;
        bit quiet;
        wa_q.delete(); wd_q.delete(); rd_cnt = 0; evt_ready = 1'b0;
        gpio_status = 32'h1;
        n = 0;
        while (evt_valid !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        checks++;
        if (evt_valid !== 1'b1) $display("FAIL evt_wait: evt_valid=%b want 1", evt_valid); else passed++;
        checks++;
        if (rd_cnt != 1) $display("FAIL svc_reads: got %0d want 1", rd_cnt); else passed++;
        checks++;
        if (wa_q.size() != 1) $display("FAIL svc_writes: got %0d want 1", wa_q.size());
        else if (wa_q[0] !== 12'h01C || wd_q[0] !== 32'h1)
            $display("FAIL svc_clear_wr: addr=%h data=%h want 01c/1", wa_q[0], wd_q[0]);
        else passed++;
        checks++;
        if (evt_status !== 32'h1) $display("FAIL evt_status: got %h want 1", evt_status); else passed++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (evt_valid !== 1'b1 || evt_status !== 32'h1) stable = 1'b0;
        end
        checks++;
        if (!stable) $display("FAIL evt_stable: valid=%b status=%h want 1/1", evt_valid, evt_status); else passed++;
        evt_ready = 1'b1;
        @(negedge aclk);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) $display("FAIL evt_handshake: evt_valid=%b want 0", evt_valid); else passed++;
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_cleared: irq=%b want 0", irq); else passed++;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (evt_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || wa_q.size() != 1) $display("FAIL no_second_evt: quiet=%b writes=%0d want 1/1", quiet, wa_q.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        aw_delay = 3; evt_ready = 1'b1;
        wa_q.delete(); wd_q.delete(); aw_hi = 0; w_hi = 0;
        gpio_status = 32'h1;
        n = 0;
        while (wa_q.size() == 0 && n < 100) begin @(negedge aclk); n++; end
        repeat (8) @(negedge aclk);
        checks++;
        if (aw_hi != 4) $display("FAIL bp_awvalid_cycles: got %0d want 4", aw_hi); else passed++;
        checks++;
        if (w_hi != 1) $display("FAIL bp_wvalid_cycles: got %0d want 1", w_hi); else passed++;
        checks++;
        if (wa_q.size() != 1) $display("FAIL bp_write_count: got %0d want 1", wa_q.size()); else passed++;
        evt_ready = 1'b0; aw_delay = 0;
    endtask

    task automatic test_spurious();
        int n;
        int t;
        wa_q.delete(); wd_q.delete(); rd_cnt = 0; evt_hi = 0; evt_ready = 1'b0;
        irq_force = 1'b1;
        n = 0;
        while (m_arvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        t = 0;
        do begin @(negedge aclk); t++; end while (m_arvalid === 1'b1 && t < 50);
        while (m_arvalid !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
        irq_force = 1'b0;
        checks++;
        if (t != 5) $display("FAIL spurious_period: arvalid restart after %0d cycles want 5", t); else passed++;
        repeat (10) @(negedge aclk);
        checks++;
        if (wa_q.size() != 0) $display("FAIL spurious_no_write: got %0d writes want 0", wa_q.size()); else passed++;
        checks++;
        if (evt_hi != 0) $display("FAIL spurious_no_evt: evt_valid high %0d cycles want 0", evt_hi); else passed++;
    endtask

    task automatic test_reset_midflight();
        int n;
        bit quiet;
        aw_delay = 100; gpio_status = 32'h1;
        n = 0;
        while (m_awvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        checks++;
        if (m_awvalid !== 1'b1) $display("FAIL mid_aw_wait: awvalid=%b want 1", m_awvalid); else passed++;
        repeat (2) @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, init_done, evt_valid} !== 7'h0)
            $display("FAIL mid_reset_async: ctrl=%b want 0000000",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, init_done, evt_valid});
        else passed++;
        gpio_status = 32'h0; aw_delay = 0;
        @(negedge aclk);
        areset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (m_awvalid !== 1'b0 || m_arvalid !== 1'b0 || init_done !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) $display("FAIL mid_wait_init: activity before init_start, want none"); else passed++;
    endtask

    task automatic test_error();
        areset = 1'b1; err_addr = 12'h020;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        checks++;
        if (err !== 1'b0) $display("FAIL err_pre: got %b want 0", err); else passed++;
        wa_q.delete(); wd_q.delete();
        do_init();
        checks++;
        if (err !== 1'b1) $display("FAIL err_bresp: got %b want 1", err); else passed++;
        checks++;
        if (init_done !== 1'b1 || wa_q.size() != 4)
            $display("FAIL err_init_completes: init_done=%b writes=%0d want 1/4", init_done, wa_q.size());
        else passed++;
        err_addr = 12'hFFF;
        repeat (4) @(negedge aclk);
    endtask

`ifdef GPIO_IRQ_SVC_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit quiet;
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        do_init();
        repeat (4) @(negedge aclk);
        ar_delay = 1000; ar_hi = 0; gpio_status = 32'h1;
        n = 0;
        while (m_arvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        n = 0;
        while (m_arvalid === 1'b1 && n < 100) begin @(negedge aclk); n++; end
        @(negedge aclk);
        checks++;
        if (ar_hi != 16) $display("FAIL to_arvalid_cycles: got %0d want 16", ar_hi); else passed++;
        checks++;
        if (err !== 1'b1 || init_done !== 1'b0)
            $display("FAIL to_flags: err=%b init_done=%b want 1/0", err, init_done);
        else passed++;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (m_arvalid !== 1'b0 || m_awvalid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) $display("FAIL to_idle: bus activity with irq high, want none"); else passed++;
        ar_delay = 0; gpio_status = 32'h0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        test_reset();
        test_init();
        test_ignore_init_start();
        test_irq_service();
        test_backpressure();
        test_spurious();
        test_reset_midflight();
        test_error();
`ifdef GPIO_IRQ_SVC_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, %0d/%0d passed", passed, checks);
        $fatal(1);
    end

endmodule

// File: doc/gpio_irq_svc.md
GPIO_IRQ_SVC -- requirements
Module: gpio_irq_svc

Interface
REQ-001 The block SHALL have parameter AXI_ADDR_WIDTH, default 12, meaning the AXI-Lite master address width.
REQ-002 The block SHALL have parameter AXI_DATA_WIDTH, default 32, meaning the AXI-Lite master data width.
REQ-003 The block SHALL have parameters DIR_INIT, EDGE_EN_INIT, EDGE_POL_INIT and MASK_INIT, each default 32'h0, meaning the values written to GPIO DIR, EDGE_EN, EDGE_POL and IRQ_MASK during init.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the handshake watchdog limit.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- aclk  in  1  clock; all logic samples on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- init_start  in  1  single-cycle pulse that begins the init sequence.
- init_done  out  1  high from init completion until the next reset.
- irq  in  1  GPIO interrupt, level.
- evt_valid / evt_ready  out / in  1 / 1  event handshake.
- evt_status  out  32  IRQ_STATUS snapshot carried by the event.
- err  out  1  sticky error flag.
- m_awaddr, m_awvalid, m_awready  out, out, in  AW / 1 / 1  write-address channel.
- m_wdata, m_wstrb, m_wvalid, m_wready  out, out, out, in  DW / DW/8 / 1 / 1  write-data channel.
- m_bresp, m_bvalid, m_bready  in, in, out  2 / 1 / 1  write-response channel.
- m_araddr, m_arvalid, m_arready  out, out, in  AW / 1 / 1  read-address channel.
- m_rdata, m_rresp, m_rvalid, m_rready  in, in, in, out  DW / 2 / 1 / 1  read-data channel.

Function
REQ-006 The FSM SHALL have states IDLE, INIT_WR, RUN, HOLD, RD_STAT, CLR, EVT and ABORT.
REQ-007 In IDLE, init_start SHALL select INIT_WR with index k=0; all other inputs are ignored.
REQ-008 INIT_WR SHALL issue four writes in this order: k0 = 0x000 DIR_INIT, k1 = 0x020 EDGE_EN_INIT, k2 = 0x024 EDGE_POL_INIT, k3 = 0x014 MASK_INIT; wstrb SHALL be 4'hF.
REQ-009 Write handshake:
- awvalid and wvalid rise in the same cycle.
- Each valid drops independently on the cycle after its own ready is sampled high.
- bready is high from issue until bvalid is sampled; the write completes on the bvalid&&bready cycle.
REQ-010 Read handshake:
- arvalid is held until arready.
- rready is high from issue until rvalid; rdata is captured on the rvalid&&rready cycle.
REQ-011 Address, data and strobe SHALL be stable while the corresponding valid is high.
REQ-012 After the k3 write completes, init_done SHALL be set and the FSM SHALL enter HOLD.
REQ-013 HOLD SHALL last exactly 2 cycles, ignoring irq, then go to RUN; this covers the GPIO clear-to-irq latency.
REQ-014 In RUN, irq=1 SHALL start a read of 0x018 (RD_STAT) on the next cycle.
REQ-015 RD_STAT outcomes:
- Captured status == 0: go to HOLD, no write, no event.
- Otherwise: go to CLR.
REQ-016 CLR SHALL write the captured status to 0x01C (W1C) with wstrb 4'hF, then go to EVT.
REQ-017 EVT:
- Assert evt_valid with evt_status = captured value, held stable until evt_ready.
- The handshake cycle leads to HOLD.
- evt_ready is ignored outside EVT.
REQ-018 bresp or rresp != 2'b00 SHALL set err; the sequence still proceeds, and for a read the returned rdata is still used.
REQ-019 irq edges arriving during RD_STAT, CLR, EVT or HOLD SHALL NOT be queued; the level is re-sampled in RUN.
REQ-020 init_start outside IDLE SHALL be ignored.

Reset
REQ-021 While areset=1, state SHALL be IDLE and all outputs 0: valids, readies, init_done, err, evt_valid, evt_status and address/data.
REQ-022 Reset assertion mid-transaction SHALL drop all valids immediately (asynchronous); after release, the block SHALL wait for a new init_start.

Configuration
REQ-023 Macro GPIO_IRQ_SVC_TIMEOUT_EN SHALL control the handshake watchdog.
- Defined: a counter clears at each transaction issue and increments each cycle until completion.
- Defined: reaching TIMEOUT_CYCLES drops all valids and readies, sets err, clears init_done, and enters ABORT, which goes to IDLE the next cycle.
- Undefined: no counter exists, and a transaction waits indefinitely.

Verification
REQ-024 Init: MASK_INIT=32'h1, EDGE_EN_INIT=32'hFFFF_FFFF, init_start pulse -> four writes in order 0x000, 0x020, 0x024, 0x014 with those data; init_done=1; slave readback of IRQ_MASK = 0x1.
REQ-025 IRQ service: GPIO bit0 rising edge -> read 0x018 returns 0x1, write 0x01C data 0x1, evt_valid with evt_status=0x1; hold evt_ready low 5 cycles -> evt_valid and evt_status stable; after the handshake, irq=0 and no second event.
REQ-026 Backpressure: slave delays awready 3 cycles and wready 0 cycles -> wvalid drops after 1 cycle, awvalid after 4; exactly one write.
REQ-027 Spurious irq: slave returns status 0 -> no write to 0x01C, no event, FSM back in RUN after 2 HOLD cycles.
REQ-028 Error: slave returns bresp=2'b10 on the k1 write -> err=1 and init still completes (init_done=1).
REQ-029 With GPIO_IRQ_SVC_TIMEOUT_EN and TIMEOUT_CYCLES=16, arready held low -> arvalid drops after the 16th cycle, err=1, init_done=0, FSM in IDLE.
